// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-port signals of the shared port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_funct3;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  // master: the arbiter itself; slave: the requesters and memory around it
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, m_ack, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_funct3
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, m_ack, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_funct3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store onto one memory port, data first with a fetch anti-starvation streak limit
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_port_arbiter_if.master  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            r_state;
  logic              r_owner;
  logic [3:0]        r_d_streak;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [2:0]        r_m_funct3;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_d_win;
  logic w_i_win;

  // Fetch only overtakes a pending data request once the streak limit is hit
  assign w_idle  = (r_state == IDLE);
  assign w_d_win = w_idle && bus.d_req && !(bus.i_req && (r_d_streak == STREAK_MAX));
  assign w_i_win = w_idle && bus.i_req && !w_d_win;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_d_streak <= 4'd0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_funct3 <= 3'b000;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_win) begin
            r_state    <= BUSY;
            r_owner    <= 1'b1;
            r_m_req    <= 1'b1;
            r_m_we     <= bus.d_we;
            r_m_addr   <= bus.d_addr;
            r_m_wdata  <= bus.d_wdata;
            r_m_funct3 <= bus.d_funct3;
            if (!bus.i_req)
              r_d_streak <= 4'd0;
            else if (r_d_streak != STREAK_MAX)
              r_d_streak <= r_d_streak + 4'd1;
          end else if (w_i_win) begin
            r_state    <= BUSY;
            r_owner    <= 1'b0;
            r_m_req    <= 1'b1;
            r_m_we     <= 1'b0;
            r_m_addr   <= bus.i_addr;
            r_m_wdata  <= '0;
            r_m_funct3 <= 3'b010;
            r_d_streak <= 4'd0;
          end
        end
        BUSY: begin
          if (bus.m_ack) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
            if (r_owner) begin
              r_d_rvalid <= 1'b1;
              if (!r_m_we)
                r_d_rdata <= bus.m_rdata;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= bus.m_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_gnt    = w_i_win;
  assign bus.d_gnt    = w_d_win;
  assign bus.i_rvalid = r_i_rvalid;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.m_req    = r_m_req;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.m_funct3 = r_m_funct3;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = 3'b000;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] or_all;
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #2;
    or_all = bus.m_addr | bus.m_wdata | bus.i_rdata | bus.d_rdata
           | {23'd0, bus.m_req, bus.m_we, bus.m_funct3, bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt};
    checks++; if (or_all !== 32'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", or_all); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
    #1;
    checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got=%b exp=10", {bus.i_gnt, bus.d_gnt}); end
    tick();
    bus.i_req = 1'b0; bus.i_addr = 32'hFFFF_FFFF;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0093; end
      #1;
      checks++;
      if ({bus.m_req, bus.m_we, bus.m_funct3, bus.i_rvalid, bus.i_gnt} !== 7'b1_0_010_0_0 || bus.m_addr !== 32'h10)
        begin errors++; $display("FAIL fetch_busy_c%0d req=%b we=%b f3=%b rv=%b addr=%h exp addr=10 f3=010", c, bus.m_req, bus.m_we, bus.m_funct3, bus.i_rvalid, bus.m_addr); end
      tick();
    end
    bus.m_ack = 1'b0;
    #1;
    checks++; if ({bus.i_rvalid, bus.d_rvalid, bus.m_req} !== 3'b100 || bus.i_rdata !== 32'h93)
      begin errors++; $display("FAIL fetch_done i_rv=%b d_rv=%b m_req=%b rdata=%h exp 1 0 0 00000093", bus.i_rvalid, bus.d_rvalid, bus.m_req, bus.i_rdata); end
    tick();
    #1;
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", bus.i_rvalid); end
    tick();
  endtask

  task automatic test_conflict();
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_funct3 = 3'b010;
    #1;
    checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin errors++; $display("FAIL conflict_gnt got=%b exp=01", {bus.i_gnt, bus.d_gnt}); end
    tick();
    bus.d_req = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    #1;
    checks++; if (bus.m_we !== 1'b1 || bus.m_wdata !== 32'hDEADBEEF || bus.m_addr !== 32'h100 || bus.i_gnt !== 1'b0)
      begin errors++; $display("FAIL conflict_store we=%b wdata=%h addr=%h i_gnt=%b exp 1 deadbeef 100 0", bus.m_we, bus.m_wdata, bus.m_addr, bus.i_gnt); end
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if ({bus.d_rvalid, bus.i_rvalid, bus.i_gnt} !== 3'b101 || bus.d_rdata !== 32'h0)
      begin errors++; $display("FAIL conflict_done d_rv=%b i_rv=%b i_gnt=%b d_rdata=%h exp 1 0 1 0", bus.d_rvalid, bus.i_rvalid, bus.i_gnt, bus.d_rdata); end
    tick();
    bus.i_req = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h13;
    #1;
    checks++; if (bus.m_addr !== 32'h20 || bus.m_we !== 1'b0) begin errors++; $display("FAIL conflict_fetch addr=%h we=%b exp 20 0", bus.m_addr, bus.m_we); end
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h13) begin errors++; $display("FAIL conflict_fetch_done rv=%b rdata=%h exp 1 13", bus.i_rvalid, bus.i_rdata); end
    tick();
  endtask

  task automatic test_anti_starvation();
    logic [9:0]  exp_fetch;
    logic [1:0]  exp_gnt;
    logic [31:0] got_rdata;
    exp_fetch = 10'b10000_10000;
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_funct3 = 3'b100;
    for (int k = 0; k < 10; k++) begin
      exp_gnt = exp_fetch[k] ? 2'b10 : 2'b01;
      #1;
      checks++; if ({bus.i_gnt, bus.d_gnt} !== exp_gnt) begin errors++; $display("FAIL streak_gnt%0d got=%b exp=%b", k, {bus.i_gnt, bus.d_gnt}, exp_gnt); end
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 32'h1000 + 32'(k);
      tick();
      bus.m_ack = 1'b0;
      #1;
      got_rdata = exp_fetch[k] ? bus.i_rdata : bus.d_rdata;
      checks++; if ({bus.i_rvalid, bus.d_rvalid} !== exp_gnt || got_rdata !== 32'h1000 + 32'(k))
        begin errors++; $display("FAIL streak_done%0d rv=%b rdata=%h exp %b %h", k, {bus.i_rvalid, bus.d_rvalid}, got_rdata, exp_gnt, 32'h1000 + 32'(k)); end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hCAFEF00D; bus.d_funct3 = 3'b001;
    #1;
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL wait_gnt got=%b exp=1", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0; bus.d_addr = 32'hFFFF; bus.d_wdata = 32'h0; bus.d_funct3 = 3'b111; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h600;
    for (int c = 1; c <= 10; c++) begin
      #1;
      checks++;
      if ({bus.m_req, bus.m_we, bus.m_funct3, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 9'b1_1_001_0000
          || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'hCAFEF00D)
        begin errors++; $display("FAIL wait_c%0d req=%b we=%b f3=%b gnt=%b%b rv=%b%b addr=%h wdata=%h", c, bus.m_req, bus.m_we, bus.m_funct3, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_addr, bus.m_wdata); end
      tick();
    end
    bus.i_req = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h9999_9999;
    #1;
    checks++; if (bus.d_rvalid !== 1'b0 || bus.m_req !== 1'b1) begin errors++; $display("FAIL wait_ack_cycle d_rv=%b m_req=%b exp 0 1", bus.d_rvalid, bus.m_req); end
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1008 || bus.m_req !== 1'b0)
      begin errors++; $display("FAIL wait_done d_rv=%b d_rdata=%h m_req=%b exp 1 00001008 0", bus.d_rvalid, bus.d_rdata, bus.m_req); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] or_all;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    #1;
    checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt got=%b exp=1", bus.i_gnt); end
    tick();
    bus.i_req = 1'b0;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    or_all = bus.m_addr | bus.m_wdata | bus.i_rdata | bus.d_rdata
           | {26'd0, bus.m_req, bus.m_we, bus.m_funct3, bus.i_rvalid | bus.d_rvalid};
    checks++; if (bus.m_req !== 1'b0 || or_all !== 32'd0) begin errors++; $display("FAIL rst_async m_req=%b or_all=%h exp 0 0", bus.m_req, or_all); end
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    tick();
    reset_n = 1'b1; bus.m_ack = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    #1;
    checks++; if ({bus.i_gnt, bus.i_rvalid} !== 2'b10) begin errors++; $display("FAIL rst_regrant gnt=%b rv=%b exp 1 0", bus.i_gnt, bus.i_rvalid); end
    tick();
    bus.i_req = 1'b0;
    #1;
    checks++; if (bus.i_rvalid !== 1'b0 || bus.m_addr !== 32'h44) begin errors++; $display("FAIL rst_new_access rv=%b addr=%h exp 0 44", bus.i_rvalid, bus.m_addr); end
    bus.m_ack = 1'b1; bus.m_rdata = 32'h55;
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h55) begin errors++; $display("FAIL rst_new_done rv=%b rdata=%h exp 1 55", bus.i_rvalid, bus.i_rdata); end
    tick();
  endtask

  task automatic test_stray_ack_withdraw();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h66;
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if ({bus.i_rvalid, bus.d_rvalid, bus.m_req} !== 3'b000) begin errors++; $display("FAIL stray_ack got=%b exp=000", {bus.i_rvalid, bus.d_rvalid, bus.m_req}); end
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    #1;
    checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL withdraw_fetch_gnt got=%b exp=1", bus.i_gnt); end
    tick();
    bus.i_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = 32'h1;
    #1;
    checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL withdraw_busy_dgnt got=%b exp=0", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h77;
    tick();
    bus.m_ack = 1'b0;
    #1;
    checks++; if ({bus.i_rvalid, bus.d_rvalid, bus.m_req, bus.d_gnt} !== 4'b1000 || bus.i_rdata !== 32'h77)
      begin errors++; $display("FAIL withdraw_done got=%b rdata=%h exp 1000 77", {bus.i_rvalid, bus.d_rvalid, bus.m_req, bus.d_gnt}, bus.i_rdata); end
    tick();
    #1;
    checks++; if ({bus.m_req, bus.d_rvalid} !== 2'b00) begin errors++; $display("FAIL withdraw_no_data got=%b exp=00", {bus.m_req, bus.d_rvalid}); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_anti_starvation();
    test_wait_states();
    test_reset_mid_access();
    test_stray_ack_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
